// File: rtl/subcarrier_nco.sv
// NTSC colour-subcarrier NCO: 32-bit phase accumulator, quadrature sine/cosine
// LUT outputs, and an hsync-timed colour-burst window with burst sample.
//
// Burst FSM states:
//   state    | meaning
//   ST_IDLE  | waiting for an hsync rising edge
//   ST_DELAY | counting BURST_DELAY clocks from the hsync edge
//   ST_BURST | burst window open for BURST_LEN clocks
module subcarrier_nco #(
    parameter int                     PHASE_WIDTH = 32,
    parameter logic [PHASE_WIDTH-1:0] PHASE_INC   = 179813221,
    parameter int                     BURST_DELAY = 456,
    parameter int                     BURST_LEN   = 770
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PHASE_WIDTH-1:0] inc_in,
    input  logic                   inc_load,
    input  logic                   field_sync,
    input  logic                   hsync,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic signed [7:0]      sin_out,
    output logic signed [7:0]      cos_out,
    output logic                   burst_active,
    output logic signed [7:0]      burst_out
);

    localparam int CNT_MAX = (BURST_DELAY > BURST_LEN) ? BURST_DELAY : BURST_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(BURST_DELAY - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0]   phase_q, phase_d;
    logic [PHASE_WIDTH-1:0]   inc_q, inc_d;
    logic signed [7:0]        sin_q, sin_d;
    logic signed [7:0]        cos_q, cos_d;
    logic                     burst_active_q, burst_active_d;
    logic                     field_sync_q, hsync_q;
    logic                     fs_edge, hs_edge;
    logic [5:0]               idx_sin, idx_cos;
    logic signed [7:0]        sin_neg;

    // First quadrant of round(127*sin(2*pi*k/64)), k = 0..16.
    function automatic logic [6:0] quarter_sin(input logic [4:0] k);
        logic [6:0] v;
        case (k)
            5'd0:    v = 7'd0;
            5'd1:    v = 7'd12;
            5'd2:    v = 7'd25;
            5'd3:    v = 7'd37;
            5'd4:    v = 7'd49;
            5'd5:    v = 7'd60;
            5'd6:    v = 7'd71;
            5'd7:    v = 7'd81;
            5'd8:    v = 7'd90;
            5'd9:    v = 7'd98;
            5'd10:   v = 7'd106;
            5'd11:   v = 7'd112;
            5'd12:   v = 7'd117;
            5'd13:   v = 7'd122;
            5'd14:   v = 7'd125;
            5'd15:   v = 7'd126;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    // Full 64-entry table folded onto the quarter wave: bit 4 mirrors, bit 5 negates.
    function automatic logic signed [7:0] sine_lut(input logic [5:0] idx);
        logic [4:0]        off;
        logic signed [7:0] mag;
        off = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
        mag = $signed({1'b0, quarter_sin(off)});
        return idx[5] ? -mag : mag;
    endfunction

    // Edge detection, increment register, accumulator and LUT lookups.
    always_comb begin
        fs_edge        = field_sync & ~field_sync_q;
        hs_edge        = hsync & ~hsync_q;
        inc_d          = inc_load ? inc_in : inc_q;
        phase_d        = fs_edge ? '0 : phase_q + inc_q;
        idx_sin        = phase_q[PHASE_WIDTH-1 -: 6];
        idx_cos        = idx_sin + 6'd16;
        sin_d          = sine_lut(idx_sin);
        cos_d          = sine_lut(idx_cos);
        burst_active_d = (state_q == ST_BURST);
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q        <= '0;
            inc_q          <= PHASE_INC;
            sin_q          <= '0;
            cos_q          <= '0;
            burst_active_q <= 1'b0;
            field_sync_q   <= 1'b0;
            hsync_q        <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            inc_q          <= inc_d;
            sin_q          <= sin_d;
            cos_q          <= cos_d;
            burst_active_q <= burst_active_d;
            field_sync_q   <= field_sync;
            hsync_q        <= hsync;
        end
    end

    // Burst FSM next state; hsync edges outside IDLE are deliberately ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_edge) begin
                    state_d = ST_DELAY;
                    cnt_d   = '0;
                end
            end
            ST_DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BURST: begin
                if (cnt_q == BURST_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Burst FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Burst sample is the registered sine inverted and halved; sin never reaches -128.
    always_comb begin
        sin_neg   = -sin_q;
        burst_out = burst_active_q ? (sin_neg >>> 1) : 8'sd0;
    end

    assign phase        = phase_q;
    assign sin_out      = sin_q;
    assign cos_out      = cos_q;
    assign burst_active = burst_active_q;

endmodule
